corr_multi: RTL and testbench

//  Multi-channel windowed correlator: N_CHAN independent (x,y) bit-pairs, per-channel counts of
//  x, y, x&y, x^y over a fixed window of 2**WINDOW_LOG2 enabled cycles, snapshotted at window end.

---
 rtl/corr_multi.sv | 120 ++++++++++++
 tb/tb_corr_multi.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/corr_multi.sv
// corr_multi: multi-channel windowed x/y correlator with snapshot readout and control over a BytePipe
module corr_multi #(
  parameter int N_CHAN = 4,
  parameter int WINDOW_LOG2 = 8,
  parameter logic [7:0] VERSION = 8'h01
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cg,
  input  logic [N_CHAN-1:0] i_x,
  input  logic [N_CHAN-1:0] i_y,
  input  logic [7:0]        i_bp_data,
  input  logic              i_bp_valid,
  output logic              o_bp_ready,
  output logic [7:0]        o_bp_data,
  output logic              o_bp_valid,
  input  logic              i_bp_ready
);
  localparam int W = WINDOW_LOG2 + 1;
  localparam int NC = 4 * N_CHAN;
  typedef enum logic [1:0] {IDLE, WDATA, REPLY} state_t;
  state_t state;
  logic [6:0] addr;
  logic [1:0] ctrl;
  logic [7:0] win_seq;
  logic [WINDOW_LOG2-1:0] win_ctr;
  logic [W-1:0] live [NC];
  logic [W-1:0] snap [NC];
  logic [W-1:0] nxt [NC];
  logic [NC-1:0] term;
  logic [8:0] sat;
  logic [7:0] rd_data;
  logic acc, wend, wr, clr;
  assign acc = i_cg & ctrl[0];
  assign wend = acc & (&win_ctr);
  assign wr = i_cg & i_bp_valid & (state == WDATA) & (addr == 7'd4);
  assign clr = wr & i_bp_data[2];
  // counter slot 4c+k holds channel c, term k: x, y, x&y, x^y
  always_comb begin
    term = '0;
    for (int c = 0; c < N_CHAN; c++) begin
      term[4*c]   = i_x[c];
      term[4*c+1] = i_y[c];
      term[4*c+2] = i_x[c] & i_y[c];
      term[4*c+3] = i_x[c] ^ i_y[c];
    end
    for (int i = 0; i < NC; i++) nxt[i] = live[i] + W'(term[i]);
  end
  always_comb begin
    sat = '0;
    case (i_bp_data[6:0])
      7'd0:    rd_data = VERSION;
      7'd1:    rd_data = 8'(N_CHAN);
      7'd2:    rd_data = 8'(WINDOW_LOG2);
      7'd3:    rd_data = win_seq;
      7'd4:    rd_data = {6'b0, ctrl};
      default: rd_data = 8'h00;
    endcase
    for (int i = 0; i < NC; i++)
      if ({1'b0, i_bp_data[6:0]} == 8'(i + 5)) begin
        sat = 9'(snap[i]);
        rd_data = sat[8] ? 8'hFF : sat[7:0];
      end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      win_ctr <= '0;
      win_seq <= '0;
      for (int i = 0; i < NC; i++) begin
        live[i] <= '0;
        snap[i] <= '0;
      end
    end else if (clr) begin
      win_ctr <= '0;
      win_seq <= '0;
      for (int i = 0; i < NC; i++) begin
        live[i] <= '0;
        snap[i] <= '0;
      end
    end else if (acc) begin
      win_ctr <= win_ctr + 1'b1;
      if (wend) win_seq <= win_seq + 8'd1;
      for (int i = 0; i < NC; i++) begin
        live[i] <= wend ? '0 : nxt[i];
        if (wend && !ctrl[1]) snap[i] <= nxt[i];
      end
    end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      o_bp_ready <= 1'b1;
      o_bp_valid <= 1'b0;
      o_bp_data <= 8'h00;
      addr <= '0;
      ctrl <= 2'b01;
    end else if (i_cg)
      case (state)
        IDLE: if (i_bp_valid) begin
          if (i_bp_data[7]) begin
            state <= WDATA;
            addr <= i_bp_data[6:0];
          end else begin
            state <= REPLY;
            o_bp_data <= rd_data;
            o_bp_valid <= 1'b1;
            o_bp_ready <= 1'b0;
          end
        end
        WDATA: if (i_bp_valid) begin
          state <= IDLE;
          if (addr == 7'd4) ctrl <= i_bp_data[1:0];
        end
        REPLY: if (i_bp_ready) begin
          state <= IDLE;
          o_bp_valid <= 1'b0;
          o_bp_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_corr_multi.sv
// tb_corr_multi: directed bench for corr_multi with a counting model checked every cycle
module tb_corr_multi;
  localparam int NC = 2;
  localparam int WL = 8;
  logic i_clk = 0;
  logic i_rst_n = 0;
  logic i_cg;
  logic [NC-1:0] i_x = 0;
  logic [NC-1:0] i_y = 0;
  logic [7:0] i_bp_data = 0;
  logic i_bp_valid = 0;
  logic i_bp_ready = 1;
  logic o_bp_ready, o_bp_valid;
  logic [7:0] o_bp_data;
  int vecs = 0;
  int errs = 0;
  bit rnd_cg = 0;
  // model: bus phase 0 idle, 1 awaiting write data, 2 reply pending
  int m_st = 0, m_data = 0, m_addr = 0, m_en = 1, m_frz = 0, m_seq = 0, m_n = 0;
  int m_live [NC][4];
  int m_snap [NC][4];

  corr_multi #(.N_CHAN(NC), .WINDOW_LOG2(WL), .VERSION(8'h01)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cg(i_cg), .i_x(i_x), .i_y(i_y),
    .i_bp_data(i_bp_data), .i_bp_valid(i_bp_valid), .o_bp_ready(o_bp_ready),
    .o_bp_data(o_bp_data), .o_bp_valid(o_bp_valid), .i_bp_ready(i_bp_ready)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    #2;
    i_cg = rnd_cg ? ($urandom_range(0, 99) != 0) : 1'b1;
  end

  task automatic chk(string nm, int got, int exp);
    vecs++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int reg_val(int a);
    int v;
    if (a == 0) return 1;
    if (a == 1) return NC;
    if (a == 2) return WL;
    if (a == 3) return m_seq;
    if (a == 4) return m_frz * 2 + m_en;
    if (a < 5 || a >= 5 + 4 * NC) return 0;
    v = m_snap[(a - 5) / 4][(a - 5) % 4];
    return v > 255 ? 255 : v;
  endfunction

  task automatic m_zero();
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < 4; k++) begin
        m_live[c][k] = 0;
        m_snap[c][k] = 0;
      end
    m_n = 0;
    m_seq = 0;
  endtask

  initial m_zero();

  always @(posedge i_clk or negedge i_rst_n) begin : model
    bit wr;
    int wd, tx, ty;
    if (!i_rst_n) begin
      m_zero();
      m_st = 0; m_data = 0; m_addr = 0; m_en = 1; m_frz = 0;
    end else begin
      wr = 0;
      wd = 0;
      if (i_cg) begin
        if (m_st == 2) begin
          if (i_bp_ready) m_st = 0;
        end else if (m_st == 1) begin
          if (i_bp_valid) begin
            wr = (m_addr == 4);
            wd = int'(i_bp_data);
            m_st = 0;
          end
        end else if (i_bp_valid) begin
          if (i_bp_data[7]) begin
            m_st = 1;
            m_addr = int'(i_bp_data[6:0]);
          end else begin
            m_st = 2;
            m_data = reg_val(int'(i_bp_data[6:0]));
          end
        end
      end
      if (i_cg && m_en == 1) begin
        for (int c = 0; c < NC; c++) begin
          tx = int'(i_x[c]);
          ty = int'(i_y[c]);
          m_live[c][0] += tx;
          m_live[c][1] += ty;
          m_live[c][2] += tx & ty;
          m_live[c][3] += tx ^ ty;
        end
        m_n++;
        if (m_n == (1 << WL)) begin
          if (m_frz == 0) m_snap = m_live;
          for (int c = 0; c < NC; c++)
            for (int k = 0; k < 4; k++) m_live[c][k] = 0;
          m_n = 0;
          m_seq = (m_seq + 1) % 256;
        end
      end
      if (wr) begin
        m_en = wd & 1;
        m_frz = (wd >> 1) & 1;
        if (wd[2]) m_zero();
      end
    end
  end

  always @(negedge i_clk) begin
    chk("bp_valid", int'(o_bp_valid), int'(m_st == 2));
    chk("bp_ready", int'(o_bp_ready), int'(m_st != 2));
    chk("bp_data", int'(o_bp_data), m_data);
  end

  task automatic send(input logic [7:0] b);
    bit a = 0;
    i_bp_data = b;
    i_bp_valid = 1;
    for (int n = 0; n < 200; n++) begin
      a = i_cg && o_bp_ready;
      @(negedge i_clk);
      if (a) break;
    end
    i_bp_valid = 0;
    chk("send_accept", int'(a), 1);
  endtask

  task automatic get(output logic [7:0] d);
    bit g = 0;
    d = 0;
    for (int n = 0; n < 200; n++) begin
      if (o_bp_valid && i_cg) begin
        d = o_bp_data;
        g = 1;
      end
      @(negedge i_clk);
      if (g) break;
    end
    chk("reply_seen", int'(g), 1);
  endtask

  task automatic rd_chk(string nm, logic [7:0] a, int exp);
    logic [7:0] d;
    send(a);
    get(d);
    chk(nm, int'(d), exp);
  endtask

  task automatic wr_reg(logic [6:0] a, logic [7:0] v);
    send({1'b1, a});
    send(v);
  endtask

  initial begin
    logic [7:0] d;
    repeat (3) @(negedge i_clk);
    chk("rst_ready", int'(o_bp_ready), 1);
    chk("rst_valid", int'(o_bp_valid), 0);
    chk("rst_data", int'(o_bp_data), 0);
    i_rst_n = 1;
    @(negedge i_clk);
    rd_chk("version", 8'h00, 8'h01);
    rd_chk("n_chan", 8'h01, 2);
    rd_chk("wlog2", 8'h02, 8);
    rd_chk("ctrl_rst", 8'h04, 8'h01);
    rd_chk("seq_rst", 8'h03, 0);
    rd_chk("unmapped_7f", 8'h7F, 0);
    // full window: ch0 x=y=1, ch1 x=1 y=0 -> 256 saturates to FF
    wr_reg(7'd4, 8'h05);
    for (int i = 0; i < 256; i++) begin
      i_x = 2'b11; i_y = 2'b01;
      @(negedge i_clk);
    end
    i_x = 0; i_y = 0;
    rd_chk("a_x0", 8'h05, 8'hFF);
    rd_chk("a_y0", 8'h06, 8'hFF);
    rd_chk("a_and0", 8'h07, 8'hFF);
    rd_chk("a_xor0", 8'h08, 8'h00);
    rd_chk("a_x1", 8'h09, 8'hFF);
    rd_chk("a_y1", 8'h0A, 8'h00);
    rd_chk("a_and1", 8'h0B, 8'h00);
    rd_chk("a_xor1", 8'h0C, 8'hFF);
    rd_chk("a_seq", 8'h03, 1);
    // partial counts: x0 for 100 cycles, ch1 x=y toggling
    wr_reg(7'd4, 8'h05);
    for (int i = 0; i < 256; i++) begin
      i_x = {i[0], 1'(i < 100)}; i_y = {i[0], 1'b0};
      @(negedge i_clk);
    end
    rd_chk("b_x0", 8'h05, 8'h64);
    rd_chk("b_y0", 8'h06, 8'h00);
    rd_chk("b_and0", 8'h07, 8'h00);
    rd_chk("b_xor0", 8'h08, 8'h64);
    rd_chk("b_x1", 8'h09, 8'h80);
    rd_chk("b_y1", 8'h0A, 8'h80);
    rd_chk("b_and1", 8'h0B, 8'h80);
    rd_chk("b_xor1", 8'h0C, 8'h00);
    rd_chk("b_seq", 8'h03, 1);
    // freeze across three windows
    i_x = 2'b01; i_y = 0;
    wr_reg(7'd4, 8'h03);
    repeat (768) @(negedge i_clk);
    rd_chk("frz_seq", 8'h03, 4);
    rd_chk("frz_x0", 8'h05, 8'h64);
    rd_chk("frz_x1", 8'h09, 8'h80);
    rd_chk("frz_ctrl", 8'h04, 8'h03);
    wr_reg(7'd4, 8'h01);
    for (int n = 0; n < 300; n++) begin
      @(negedge i_clk);
      if (m_n == 0) break;
    end
    rd_chk("unfrz_x0", 8'h05, 8'hFF);
    rd_chk("unfrz_y0", 8'h06, 8'h00);
    rd_chk("unfrz_xor0", 8'h08, 8'hFF);
    rd_chk("unfrz_x1", 8'h09, 8'h00);
    rd_chk("unfrz_seq", 8'h03, 5);
    // downstream backpressure holds the reply
    i_bp_ready = 0;
    send(8'h04);
    repeat (5) begin
      chk("hold_valid", int'(o_bp_valid), 1);
      chk("hold_data", int'(o_bp_data), 8'h01);
      chk("hold_ready", int'(o_bp_ready), 0);
      @(negedge i_clk);
    end
    i_bp_ready = 1;
    get(d);
    chk("hold_final", int'(d), 8'h01);
    // sporadic clock-gate with random samples; model checks every snapshot
    rnd_cg = 1;
    for (int i = 0; i < 600; i++) begin
      i_x = 2'($urandom); i_y = 2'($urandom);
      @(negedge i_clk);
    end
    for (int a = 3; a < 13; a++) begin
      send(8'(a));
      get(d);
    end
    wr_reg(7'd3, 8'hFF);
    rd_chk("cg_version", 8'h00, 8'h01);
    rd_chk("cg_unmapped_7f", 8'h7F, 0);
    rd_chk("cg_past_map", 8'h0D, 0);
    rd_chk("cg_ctrl", 8'h04, 8'h01);
    rnd_cg = 0;
    repeat (2) @(negedge i_clk);
    // clear landing on the window-end cycle wins
    i_x = 2'b01; i_y = 2'b01;
    send(8'h84);
    for (int n = 0; n < 300; n++) begin
      if (m_n == 255) break;
      @(negedge i_clk);
    end
    send(8'h05);
    rd_chk("clr_x0", 8'h05, 0);
    rd_chk("clr_and0", 8'h07, 0);
    rd_chk("clr_seq", 8'h03, 0);
    // async reset in the middle of a reply
    i_bp_ready = 0;
    send(8'h00);
    #3 i_rst_n = 0;
    #1;
    chk("arst_valid", int'(o_bp_valid), 0);
    chk("arst_ready", int'(o_bp_ready), 1);
    chk("arst_data", int'(o_bp_data), 0);
    @(negedge i_clk);
    i_bp_ready = 1;
    i_rst_n = 1;
    @(negedge i_clk);
    rd_chk("post_rst_ctrl", 8'h04, 8'h01);
    rd_chk("post_rst_seq", 8'h03, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
